// File: rtl/message_extractor.sv
// message_extractor
//   Recovers a hidden message from stego pixels. Each pixel read from the
//   input FIFO contributes its LSB_N low bits (MSB-first) to an 8-bit byte.
//   Every completed byte is written to the output FIFO. The run ends either
//   after msg_len bytes (length mode) or when a 0x00 byte is assembled
//   (terminator mode, msg_len == 0). A 0x00 byte in terminator mode is not
//   written.
//
// Parameters
//   LSB_N          LSBs taken per pixel, 1 or 2
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          one-cycle start pulse, honoured only while idle
//   msg_len        byte count to extract (0 = terminator mode), latched on start
//   ff_pixel_data  pixel from input FIFO, valid the cycle after ff_pixel_rd
//   ff_pixel_empty input FIFO empty
//   ff_pixel_rd    input FIFO read strobe
//   ff_full        output FIFO full
//   ff_data        recovered message byte
//   ff_wr          output FIFO write strobe
//   busy           run in progress
//   done           one-cycle completion pulse
//   byte_cnt       bytes written in the current run
module message_extractor #(
  parameter int unsigned LSB_N = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] msg_len,
  input  logic [7:0]  ff_pixel_data,
  input  logic        ff_pixel_empty,
  output logic        ff_pixel_rd,
  input  logic        ff_full,
  output logic [7:0]  ff_data,
  output logic        ff_wr,
  output logic        busy,
  output logic        done,
  output logic [15:0] byte_cnt
);

  localparam int unsigned CAPS     = 8 / LSB_N;
  localparam logic [2:0]  LAST_CAP = 3'(CAPS - 1);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state;
  logic [7:0]  byte_q;
  logic [2:0]  bit_cnt;
  logic [15:0] len_q;
  logic [15:0] cnt_next;
  logic        term_mode;
  logic        term_hit;
  logic        last_byte;
  logic        unused_pixel_bits;

  assign unused_pixel_bits = ^ff_pixel_data[7:LSB_N];

  assign term_mode = (len_q == '0);
  assign term_hit  = term_mode && (byte_q == '0);
  assign cnt_next  = byte_cnt + 16'd1;
  // Terminator mode stops once the counter would saturate at 0xFFFF.
  assign last_byte = term_mode ? (cnt_next == '1) : (cnt_next == len_q);

  // Strobes are decoded from state and the live FIFO flags so they can never
  // fire against a flag that changed in the same cycle.
  assign ff_pixel_rd = (state == RD) && !ff_pixel_empty;
  assign ff_wr       = (state == WR) && !ff_full && !term_hit;
  assign ff_data     = byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_q   <= '0;
      bit_cnt  <= '0;
      len_q    <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= msg_len;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            byte_q   <= '0;
            busy     <= 1'b1;
            state    <= RD;
          end
        end
        RD: begin
          if (!ff_pixel_empty) state <= CAP;
        end
        CAP: begin
          byte_q <= {byte_q[7-LSB_N:0], ff_pixel_data[LSB_N-1:0]};
          if (bit_cnt == LAST_CAP) begin
            bit_cnt <= '0;
            state   <= WR;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            state   <= RD;
          end
        end
        WR: begin
          if (term_hit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (!ff_full) begin
            byte_cnt <= cnt_next;
            if (last_byte) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= RD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_message_extractor.sv
// tb_message_extractor
//   Two instances (LSB_N=1 and LSB_N=2) share one pixel-FIFO model and one
//   expected-byte scoreboard; only the selected instance is started and sees
//   a non-empty input FIFO. A negedge monitor pops the scoreboard on writes.
module tb_message_extractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [15:0] msg_len;
  logic [7:0]  pix_data = 8'h00;
  logic [1:0]  pix_empty;
  logic [1:0]  pix_rd;
  logic        full;
  logic [7:0]  data [2];
  logic [1:0]  wr;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [15:0] cnt [2];

  int          checks = 0;
  int          errors = 0;
  int          sel = 0;
  bit          rand_en = 1'b0;
  bit          stall = 1'b0;
  logic [7:0]  pix_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  px_list [$];
  int          pairs [8] = '{1, 0, 2, 0, 1, 2, 0, 1};

  always #5 clk = ~clk;

  message_extractor #(.LSB_N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .msg_len(msg_len),
    .ff_pixel_data(pix_data), .ff_pixel_empty(pix_empty[0]), .ff_pixel_rd(pix_rd[0]),
    .ff_full(full), .ff_data(data[0]), .ff_wr(wr[0]),
    .busy(busy[0]), .done(done[0]), .byte_cnt(cnt[0])
  );

  message_extractor #(.LSB_N(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .msg_len(msg_len),
    .ff_pixel_data(pix_data), .ff_pixel_empty(pix_empty[1]), .ff_pixel_rd(pix_rd[1]),
    .ff_full(full), .ff_data(data[1]), .ff_wr(wr[1]),
    .busy(busy[1]), .done(done[1]), .byte_cnt(cnt[1])
  );

  // Input FIFO model: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (pix_rd[sel] && pix_q.size() > 0) pix_data <= pix_q.pop_front();
  end

  // Flag driver, updated just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (rand_en) begin
      full  = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 3) == 0);
    end
    for (int k = 0; k < 2; k++)
      pix_empty[k] = (k != sel) || stall || (pix_q.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ((pix_rd[k] && wr[k]) || (pix_rd[k] && pix_empty[k]) || (wr[k] && full)) begin
          errors++;
          $display("FAIL protocol dut%0d rd=%0b wr=%0b empty=%0b full=%0b",
                   k, pix_rd[k], wr[k], pix_empty[k], full);
        end
        if (wr[k]) begin
          checks++;
          if (k != sel) begin
            errors++;
            $display("FAIL stray_write dut%0d got wr=1 want 0", k);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write dut%0d got %0h want no write", k, data[k]);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data[k] !== e) begin
              errors++;
              $display("FAIL byte_data dut%0d got %0h want %0h", k, data[k], e);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: concatenate pixel LSB fields into a bitstream, cut into bytes,
  // stop at msg_len bytes or at the first zero byte in terminator mode.
  task automatic build_expected(input int lsb, input int len, output int n);
    bit         bits [$];
    logic [7:0] b;
    foreach (px_list[i])
      for (int j = lsb - 1; j >= 0; j--) bits.push_back(px_list[i][j]);
    n = 0;
    for (int i = 0; i + 8 <= bits.size(); i += 8) begin
      b = '0;
      for (int j = 0; j < 8; j++) b = {b[6:0], bits[i+j]};
      if (len == 0 && b == 8'h00) break;
      exp_q.push_back(b);
      n++;
      if (len != 0 && n == len) break;
    end
  endtask

  task automatic encode(input int lsb, input logic [7:0] b);
    for (int p = 0; p < 8 / lsb; p++) begin
      int mask = (1 << lsb) - 1;
      int v    = (int'(b) >> (8 - lsb * (p + 1))) & mask;
      int r    = int'($urandom_range(0, 255));
      px_list.push_back(8'((r & ~mask) | v));
    end
  endtask

  task automatic feed();
    foreach (px_list[i]) pix_q.push_back(px_list[i]);
  endtask

  task automatic do_start(input int k, input int len);
    start[k] = 1'b1;
    msg_len  = 16'(len);
    tick();
    start[k] = 1'b0;
    check("busy_after_start", 32'(busy[k]), 32'd1);
  endtask

  task automatic wait_done(input int k, input int exp_n, input int budget);
    int t = 0;
    while (!done[k] && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (!done[k]) begin
      errors++;
      $display("FAIL done_timeout dut%0d got no done want done within %0d cycles", k, budget);
      exp_q.delete();
      pix_q.delete();
    end else begin
      check("byte_cnt", 32'(cnt[k]), 32'(exp_n));
      check("busy_at_done", 32'(busy[k]), 32'd0);
      tick();
      check("done_pulse_width", 32'(done[k]), 32'd0);
    end
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("pixels_left", 32'(pix_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input int k);
    check("reset_outputs", {4'h0, pix_rd[k], wr[k], data[k], busy[k], done[k], cnt[k]}, 32'd0);
  endtask

  initial begin
    int n;
    int len;
    int lsb;
    int nb;
    rst_n     = 1'b0;
    start     = '0;
    msg_len   = '0;
    full      = 1'b0;
    pix_empty = '1;
    tick(3);
    for (int k = 0; k < 2; k++) check_reset_outputs(k);
    rst_n = 1'b1;
    tick(2);

    // Length mode, LSB_N=1, one byte.
    sel = 0;
    px_list = '{8'd232, 8'd82, 8'd143, 8'd82, 8'd82, 8'd82, 8'd82, 8'd232};
    exp_q.push_back(8'h20);
    feed();
    do_start(0, 1);
    wait_done(0, 1, 200);

    // Length mode, LSB_N=2, two bytes; a mid-run start must be ignored.
    sel = 1;
    px_list.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        px_list.push_back(8'((int'($urandom_range(0, 255)) & 'hFC) | pairs[r*4+i]));
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h61);
    feed();
    do_start(1, 2);
    tick(5);
    start[1] = 1'b1;
    msg_len  = 16'd7;
    tick();
    start[1] = 1'b0;
    wait_done(1, 2, 200);

    // Terminator mode: 0x41 then 0x00.
    sel = 0;
    px_list.delete();
    encode(1, 8'h41);
    encode(1, 8'h00);
    exp_q.push_back(8'h41);
    feed();
    do_start(0, 0);
    wait_done(0, 1, 300);

    // Output FIFO full while the byte is waiting.
    px_list.delete();
    encode(1, 8'hA5);
    exp_q.push_back(8'hA5);
    full = 1'b1;
    feed();
    do_start(0, 1);
    tick(20);
    check("held_byte", 32'(data[0]), 32'h0000_00A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("full_hold_wr", 32'(wr[0]), 32'd0);
      check("full_hold_data", 32'(data[0]), 32'h0000_00A5);
    end
    full = 1'b0;
    wait_done(0, 1, 50);

    // Input FIFO runs dry after three pixels.
    px_list.delete();
    encode(1, 8'h3C);
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 3; i++) pix_q.push_back(px_list[i]);
    do_start(0, 1);
    tick(8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("dry_no_read", 32'(pix_rd[0]), 32'd0);
    end
    for (int i = 3; i < 8; i++) pix_q.push_back(px_list[i]);
    wait_done(0, 1, 100);

    // Reset mid-byte, then a fresh run.
    px_list = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    feed();
    do_start(0, 1);
    tick(9);
    rst_n = 1'b0;
    tick();
    check_reset_outputs(0);
    tick();
    rst_n = 1'b1;
    tick(2);
    check("idle_after_reset", 32'(busy[0]), 32'd0);
    px_list.delete();
    encode(1, 8'h05);
    exp_q.push_back(8'h05);
    feed();
    do_start(0, 1);
    wait_done(0, 1, 200);

    // Randomized runs with random FIFO stalls on both sides.
    rand_en = 1'b1;
    for (int it = 0; it < 12; it++) begin
      sel = it % 2;
      lsb = sel + 1;
      len = int'($urandom_range(0, 4));
      px_list.delete();
      if (len == 0) begin
        nb = int'($urandom_range(0, 3));
        for (int i = 0; i < nb; i++) encode(lsb, 8'($urandom_range(1, 255)));
        encode(lsb, 8'h00);
      end else begin
        for (int i = 0; i < len; i++) encode(lsb, 8'($urandom_range(0, 255)));
      end
      build_expected(lsb, len, n);
      tick();
      feed();
      do_start(sel, len);
      wait_done(sel, n, 2000);
    end
    rand_en = 1'b0;
    full    = 1'b0;
    stall   = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no finish want finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/message_extractor.md
MESSAGE_EXTRACTOR -- requirements
Module: message_extractor

Interface
REQ-001 Parameter LSB_N, default 1: LSBs taken per stego pixel; legal values 1 or 2.
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  one-cycle pulse; begins extraction, sampled only in IDLE.
REQ-005 Port msg_len  input  16  byte count to extract, latched on start; 0 selects terminator mode.
REQ-006 Port ff_pixel_data  input  8  stego pixel from input FIFO, valid the cycle after ff_pixel_rd.
REQ-007 Port ff_pixel_empty  input  1  input FIFO empty.
REQ-008 Port ff_pixel_rd  output  1  input FIFO read strobe.
REQ-009 Port ff_full  input  1  output FIFO full.
REQ-010 Port ff_data  output  8  recovered message byte.
REQ-011 Port ff_wr  output  1  output FIFO write strobe.
REQ-012 Port busy  output  1  high from the cycle after an accepted start until DONE is entered.
REQ-013 Port done  output  1  one-cycle pulse when extraction completes.
REQ-014 Port byte_cnt  output  16  bytes written to the output FIFO in the current run.

Function
REQ-015 The block SHALL implement states IDLE, RD, CAP, WR, DONE.
REQ-016 IDLE: on start=1, latch msg_len, clear byte_cnt and the bit counter, and go to RD; otherwise remain in IDLE.
REQ-017 RD: ff_pixel_rd SHALL equal !ff_pixel_empty; if it is 1, go to CAP; otherwise stay in RD.
REQ-018 CAP: shift ff_pixel_data[LSB_N-1:0] into the byte register, MSB first, with pixel bit LSB_N-1 taken ahead of bit 0.
REQ-019 CAP: after 8/LSB_N captures (8 for LSB_N=1, 4 for LSB_N=2) go to WR; otherwise go to RD.
REQ-020 WR: ff_wr SHALL equal !ff_full, with ff_data holding the assembled byte; while ff_full=1, hold WR and keep ff_data stable.
REQ-021 In length mode, on a write increment byte_cnt; go to DONE if byte_cnt reaches msg_len, else go to RD.
REQ-022 In terminator mode, an assembled byte of 0x00 SHALL NOT be written, SHALL NOT increment byte_cnt, and SHALL cause a transition to DONE.
REQ-023 In terminator mode, a nonzero byte SHALL be written as in REQ-020.
REQ-024 In terminator mode, reaching byte_cnt=16'hFFFF SHALL force a transition to DONE after that write.
REQ-025 DONE: pulse done for one cycle, deassert busy, and return to IDLE; byte_cnt holds its value until the next start.
REQ-026 ff_pixel_rd and ff_wr SHALL never be high in the same cycle; ff_pixel_rd SHALL never be high while ff_pixel_empty=1.
REQ-027 ff_wr SHALL never be high while ff_full=1.
REQ-028 A start pulse received outside IDLE SHALL be ignored.
REQ-029 Throughput with no stalls: 2 cycles per pixel plus 1 WR cycle per byte (17 cycles/byte for LSB_N=1).
REQ-030 An empty input FIFO mid-byte SHALL stall in RD with the partial byte preserved and no timeout.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE and every output SHALL be 0: ff_pixel_rd, ff_wr, ff_data, busy, done, byte_cnt.
REQ-032 While rst_n=0, the internal byte register, bit counter and latched length SHALL be 0.
REQ-033 Reset asserted mid-run SHALL discard any partial byte immediately, with no further FIFO strobes.
REQ-034 After reset release, the block SHALL wait in IDLE for a new start.

Verification
REQ-035 LSB_N=1, msg_len=1, pixels 232,82,143,82,82,82,82,232 -> single ff_wr with ff_data=0x20, done pulse, byte_cnt=1.
REQ-036 LSB_N=2, msg_len=2, pixel LSB pairs 01,00,10,00 then 01,10,00,01 -> writes 0x48 then 0x61, done pulse, byte_cnt=2.
REQ-037 Terminator mode, LSB_N=1, pixel LSBs encoding 0x41 then 0x00 -> exactly one write, 0x41; done pulse; byte_cnt=1.
REQ-038 ff_full held high for 5 cycles in WR -> ff_wr stays 0 and ff_data stays stable; single write on release.
REQ-039 ff_pixel_empty high for 10 cycles after pixel 3 -> no ff_pixel_rd during that period; correct byte after resume.
REQ-040 rst_n pulsed low after 4 pixels, then a fresh start -> first byte is built only from pixels after the new start.
